red_pitaya_na_sweep_block: RTL and testbench

//  Network-analyzer sweep engine for the IQ block. Drives the IQ fgen phase increment (freq_o) over N

---
 rtl/red_pitaya_na_sweep_block_pkg.sv | 25 ++
 rtl/red_pitaya_na_sweep_block_if.sv | 11 +
 rtl/red_pitaya_na_sweep_block_fifo.sv | 41 ++++
 rtl/red_pitaya_na_sweep_block.sv | 157 +++++++++++++++
 tb/tb_red_pitaya_na_sweep_block.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/red_pitaya_na_sweep_block_pkg.sv
// red_pitaya_na_sweep_block_pkg: register map, FSM states and helpers for the network-analyzer sweep engine.
package red_pitaya_na_sweep_block_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        ACCUM  = 3'd2,
        PUSH   = 3'd3,
        DONE   = 3'd4
    } state_t;
    localparam logic [15:0] REG_CTRL   = 16'h100;
    localparam logic [15:0] REG_START  = 16'h104;
    localparam logic [15:0] REG_STEP   = 16'h108;
    localparam logic [15:0] REG_POINTS = 16'h10C;
    localparam logic [15:0] REG_AVG    = 16'h110;
    localparam logic [15:0] REG_SLEEP  = 16'h114;
    localparam logic [15:0] REG_STATUS = 16'h118;
    localparam logic [15:0] REG_I_LO   = 16'h120;
    localparam logic [15:0] REG_I_HI   = 16'h124;
    localparam logic [15:0] REG_Q_LO   = 16'h128;
    localparam logic [15:0] REG_Q_HI   = 16'h12C;
    // an averages value of 0 still accumulates one sample
    function automatic logic [31:0] max1(input logic [31:0] v);
        return v == 32'd0 ? 32'd1 : v;
    endfunction
endpackage

// File: rtl/red_pitaya_na_sweep_block_if.sv
// red_pitaya_na_sweep_block_if: system-bus register access port (strobed read/write, registered ack/rdata).
interface red_pitaya_na_sweep_block_if;
    logic [15:0] addr;
    logic        wen;
    logic        ren;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    modport master (output addr, wen, ren, wdata, input ack, rdata);
    modport slave (input addr, wen, ren, wdata, output ack, rdata);
endinterface

// File: rtl/red_pitaya_na_sweep_block_fifo.sv
// red_pitaya_na_sweep_block_fifo: synchronous FIFO with flush and occupancy count; head is read combinationally.
module red_pitaya_na_sweep_block_fifo #(
    parameter int WIDTH = 96,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    assign full    = count[AW];
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    always_ff @(posedge clk)
        if (do_push && !flush) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/red_pitaya_na_sweep_block.sv
// red_pitaya_na_sweep_block: linear frequency sweep that settles, averages both IQ quadratures per point
// and queues the {I,Q} sums in a FIFO drained over the system bus.
module red_pitaya_na_sweep_block
    import red_pitaya_na_sweep_block_pkg::*;
#(
    parameter int LPFBITS   = 24,
    parameter int PHASEBITS = 32,
    parameter int SUMBITS   = 48,
    parameter int FIFOAW    = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic signed [LPFBITS-1:0] quad1_i,
    input  logic signed [LPFBITS-1:0] quad2_i,
    output logic [PHASEBITS-1:0]      freq_o,
    output logic                      freq_upd_o,
    output logic                      busy_o,
    red_pitaya_na_sweep_block_if.slave bus
);
    state_t                  state, state_next;
    logic [PHASEBITS-1:0]    start_freq, step_freq, sh_step;
    logic [31:0]             points, averages, sleep_cycles;
    logic [31:0]             sh_points, sh_avg, sh_sleep, cnt, point;
    logic signed [SUMBITS-1:0] sum_i, sum_q, ext_i, ext_q, nxt_i, nxt_q;
    logic                    overflow, ovf_add, ctrl_wr, start, abort, push, pop, full, empty;
    logic [FIFOAW:0]         count;
    logic [2*SUMBITS-1:0]    head;
    logic signed [63:0]      head_i, head_q;
    logic [31:0]             rd_mux;
    assign ctrl_wr = bus.wen && bus.addr == REG_CTRL;
    assign start   = ctrl_wr && bus.wdata[0];
    assign abort   = ctrl_wr && bus.wdata[1];
    assign pop     = bus.ren && bus.addr == REG_Q_HI;
    assign busy_o  = state == SETTLE || state == ACCUM || state == PUSH;
    assign ext_i   = SUMBITS'(quad1_i);
    assign ext_q   = SUMBITS'(quad2_i);
    assign nxt_i   = sum_i + ext_i;
    assign nxt_q   = sum_q + ext_q;
    // signed overflow: operands share a sign the result does not
    assign ovf_add = (sum_i[SUMBITS-1] == ext_i[SUMBITS-1] && nxt_i[SUMBITS-1] != sum_i[SUMBITS-1]) ||
                     (sum_q[SUMBITS-1] == ext_q[SUMBITS-1] && nxt_q[SUMBITS-1] != sum_q[SUMBITS-1]);
    assign head_i  = 64'(signed'(head[2*SUMBITS-1:SUMBITS]));
    assign head_q  = 64'(signed'(head[SUMBITS-1:0]));
    red_pitaya_na_sweep_block_fifo #(.WIDTH(2*SUMBITS), .AW(FIFOAW)) fifo (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .flush (start),
        .push  (push),
        .pop   (pop),
        .wdata ({sum_i, sum_q}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) state <= IDLE;
        else state <= state_next;
    always_comb begin
        state_next = state;
        push       = 1'b0;
        if (start) state_next = points == 32'd0 ? DONE : SETTLE;
        else if (abort) state_next = IDLE;
        else
            case (state)
                SETTLE:  state_next = cnt == sh_sleep ? ACCUM : SETTLE;
                ACCUM:   state_next = cnt == sh_avg - 32'd1 ? PUSH : ACCUM;
                PUSH: begin
                    push       = !full;
                    state_next = full ? PUSH : (point + 32'd1 == sh_points ? DONE : SETTLE);
                end
                DONE:    state_next = IDLE;
                default: state_next = state;
            endcase
    end
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            cnt        <= '0;
            point      <= '0;
            freq_o     <= '0;
            freq_upd_o <= 1'b0;
            sum_i      <= '0;
            sum_q      <= '0;
            overflow   <= 1'b0;
            sh_step    <= '0;
            sh_points  <= '0;
            sh_avg     <= '0;
            sh_sleep   <= '0;
        end else begin
            cnt        <= (start || state_next != state) ? '0 : cnt + 32'd1;
            freq_upd_o <= 1'b0;
            if (start) begin
                point     <= '0;
                sh_step   <= step_freq;
                sh_points <= points;
                sh_avg    <= max1(averages);
                sh_sleep  <= sleep_cycles;
                if (points != 32'd0) begin
                    freq_o     <= start_freq;
                    freq_upd_o <= 1'b1;
                end
            end else if (push) begin
                point <= point + 32'd1;
                if (state_next == SETTLE) begin
                    freq_o     <= freq_o + sh_step;
                    freq_upd_o <= 1'b1;
                end
            end
            if (state == SETTLE) begin
                sum_i <= '0;
                sum_q <= '0;
            end else if (state == ACCUM) begin
                sum_i <= nxt_i;
                sum_q <= nxt_q;
            end
            if (start) overflow <= 1'b0;
            else if (state == ACCUM && ovf_add) overflow <= 1'b1;
        end
    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            REG_START:  rd_mux = 32'(start_freq);
            REG_STEP:   rd_mux = 32'(step_freq);
            REG_POINTS: rd_mux = points;
            REG_AVG:    rd_mux = averages;
            REG_SLEEP:  rd_mux = sleep_cycles;
            REG_STATUS: rd_mux = {8'd0, 8'(count), 7'd0, overflow, 5'd0, state};
            REG_I_LO:   rd_mux = empty ? '0 : head_i[31:0];
            REG_I_HI:   rd_mux = empty ? '0 : head_i[63:32];
            REG_Q_LO:   rd_mux = empty ? '0 : head_q[31:0];
            REG_Q_HI:   rd_mux = empty ? '0 : head_q[63:32];
            default:    rd_mux = '0;
        endcase
    end
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            bus.ack      <= 1'b0;
            bus.rdata    <= '0;
            start_freq   <= '0;
            step_freq    <= '0;
            points       <= '0;
            averages     <= '0;
            sleep_cycles <= '0;
        end else begin
            bus.ack <= bus.wen || bus.ren;
            if (bus.ren) bus.rdata <= rd_mux;
            if (bus.wen)
                case (bus.addr)
                    REG_START:  start_freq   <= PHASEBITS'(bus.wdata);
                    REG_STEP:   step_freq    <= PHASEBITS'(bus.wdata);
                    REG_POINTS: points       <= bus.wdata;
                    REG_AVG:    averages     <= bus.wdata;
                    REG_SLEEP:  sleep_cycles <= bus.wdata;
                    default:    ;
                endcase
        end
endmodule

// File: tb/tb_red_pitaya_na_sweep_block.sv
// tb_red_pitaya_na_sweep_block: directed sweeps with a read-data scoreboard; SUMBITS is narrowed to 32 so
// the averaging-range boundary (2^(SUMBITS-LPFBITS) = 256) is reachable in a short run.
module tb_red_pitaya_na_sweep_block;
    import red_pitaya_na_sweep_block_pkg::*;
    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic signed [23:0] quad1 = '0, quad2 = '0;
    logic [31:0]        freq;
    logic               freq_upd, busy;
    int                 checks = 0, failures = 0, upd_cnt = 0;
    logic [31:0]        exp_q[$];
    string              nm_q[$];
    logic [31:0]        freq_log[$];
    logic [31:0]        exp_f[$];
    logic               rd_pend = 1'b0;
    red_pitaya_na_sweep_block_if bus();
    red_pitaya_na_sweep_block #(.SUMBITS(32)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .quad1_i    (quad1),
        .quad2_i    (quad2),
        .freq_o     (freq),
        .freq_upd_o (freq_upd),
        .busy_o     (busy),
        .bus        (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) rd_pend <= bus.ren;
    always @(negedge clk)
        if (rd_pend) begin
            string       n;
            logic [31:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read: rdata=%h with nothing expected", bus.rdata);
            end else begin
                n = nm_q.pop_front();
                e = exp_q.pop_front();
                if (bus.ack !== 1'b1 || bus.rdata !== e) begin
                    failures++;
                    $display("FAIL %s: ack=%b rdata=%h expected ack=1 rdata=%h", n, bus.ack, bus.rdata, e);
                end
            end
        end
    always @(negedge clk)
        if (freq_upd === 1'b1) begin
            upd_cnt++;
            freq_log.push_back(freq);
        end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, e);
        end
    endtask
    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        @(posedge clk);
        #1 bus.addr = a; bus.wdata = d; bus.wen = 1'b1;
        @(posedge clk);
        #1 bus.wen = 1'b0;
    endtask
    task automatic rd(input logic [15:0] a, input logic [31:0] e, input string nm);
        @(posedge clk);
        #1 bus.addr = a; bus.ren = 1'b1;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1 bus.ren = 1'b0;
    endtask
    task automatic cfg(input logic [31:0] sf, st, pts, avg, slp);
        wr(REG_START, sf);
        wr(REG_STEP, st);
        wr(REG_POINTS, pts);
        wr(REG_AVG, avg);
        wr(REG_SLEEP, slp);
    endtask
    task automatic wait_idle(input int max, input string nm, output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < max) begin
            n++;
            @(negedge clk);
        end
        chk({nm, "_sweep_ends"}, {31'd0, busy}, 32'd0);
    endtask
    task automatic chk_freqs(input string nm);
        chk({nm, "_upd_count"}, freq_log.size(), exp_f.size());
        for (int i = 0; i < exp_f.size(); i++)
            chk($sformatf("%s_freq%0d", nm, i), i < freq_log.size() ? freq_log[i] : 32'hDEAD_BEEF, exp_f[i]);
    endtask
    initial begin
        int n, base;
        bus.addr = '0; bus.wdata = '0; bus.wen = 1'b0; bus.ren = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_freq", freq, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_upd", {31'd0, freq_upd}, 0);
        chk("rst_ack", {31'd0, bus.ack}, 0);
        rstn = 1'b1;
        // basic 3-point sweep
        quad1 = 24'sd5; quad2 = -24'sd3;
        cfg(1000, 10, 3, 4, 2);
        freq_log.delete();
        wr(REG_CTRL, 1);
        wait_idle(200, "basic", n);
        chk("basic_busy_cycles", n, 24);
        chk("basic_freq_final", freq, 1020);
        exp_f = '{1000, 1010, 1020};
        chk_freqs("basic");
        rd(REG_STATUS, 32'h0003_0000, "basic_status");
        for (int i = 0; i < 3; i++) begin
            rd(REG_I_LO, 20, $sformatf("basic_i_lo%0d", i));
            rd(REG_I_HI, 0, $sformatf("basic_i_hi%0d", i));
            rd(REG_Q_LO, 32'hFFFF_FFF4, $sformatf("basic_q_lo%0d", i));
            rd(REG_Q_HI, 32'hFFFF_FFFF, $sformatf("basic_q_hi%0d", i));
        end
        rd(REG_STATUS, 0, "basic_status_drained");
        // phase word wraps modulo 2^32
        cfg(32'hFFFF_FFFB, 10, 2, 1, 0);
        freq_log.delete();
        wr(REG_CTRL, 1);
        wait_idle(100, "wrap", n);
        exp_f = '{32'hFFFF_FFFB, 32'd5};
        chk_freqs("wrap");
        // points=0: straight to DONE, flushes the two wrap entries, no frequency pulse
        base = upd_cnt;
        wr(REG_POINTS, 0);
        wr(REG_CTRL, 1);
        @(negedge clk);
        chk("zero_busy", {31'd0, busy}, 0);
        rd(REG_STATUS, 0, "zero_status_flushed");
        rd(REG_Q_HI, 0, "empty_pop_data");
        rd(REG_STATUS, 0, "empty_pop_count");
        chk("zero_no_upd", upd_cnt - base, 0);
        chk("zero_freq_kept", freq, 5);
        // averaging range boundary
        quad1 = 24'h80_0000; quad2 = '0;
        cfg(0, 0, 1, 256, 0);
        wr(REG_CTRL, 1);
        wait_idle(400, "ovf_edge", n);
        rd(REG_STATUS, 32'h0001_0000, "ovf_edge_status");
        rd(REG_I_LO, 32'h8000_0000, "ovf_edge_i_lo");
        rd(REG_I_HI, 32'hFFFF_FFFF, "ovf_edge_i_hi");
        rd(REG_Q_HI, 0, "ovf_edge_pop");
        wr(REG_AVG, 257);
        wr(REG_CTRL, 1);
        wait_idle(400, "ovf", n);
        rd(REG_STATUS, 32'h0001_0100, "ovf_status");
        rd(REG_Q_HI, 0, "ovf_pop");
        // pop lands on the same edge as the second push
        quad1 = 24'sd7; quad2 = -24'sd3;
        cfg(50, 1, 2, 1, 0);
        wr(REG_CTRL, 1);
        repeat (4) @(posedge clk);
        rd(REG_Q_HI, 32'hFFFF_FFFF, "pushpop_data");
        wait_idle(50, "pushpop", n);
        rd(REG_STATUS, 32'h0001_0000, "pushpop_count");
        rd(REG_I_LO, 7, "pushpop_i_lo");
        // FIFO full stalls the sweep until the PS drains it
        quad1 = 24'sd1; quad2 = 24'sd2;
        cfg(0, 1, 20, 1, 0);
        base = upd_cnt;
        wr(REG_CTRL, 1);
        repeat (100) @(negedge clk);
        chk("stall_freq", freq, 16);
        chk("stall_busy", {31'd0, busy}, 1);
        chk("stall_upd", upd_cnt - base, 17);
        rd(REG_STATUS, 32'h0010_0003, "stall_status");
        rd(REG_Q_HI, 0, "stall_pop1");
        repeat (20) @(negedge clk);
        chk("stall_resumed_freq", freq, 17);
        for (int i = 0; i < 3; i++) rd(REG_Q_HI, 0, $sformatf("stall_pop%0d", i + 2));
        wait_idle(200, "stall", n);
        chk("stall_freq_final", freq, 19);
        chk("stall_upd_total", upd_cnt - base, 20);
        rd(REG_STATUS, 32'h0010_0000, "stall_status_done");
        for (int i = 0; i < 16; i++) begin
            rd(REG_I_LO, 1, $sformatf("stall_drain_i%0d", i));
            rd(REG_Q_HI, 0, $sformatf("stall_drain_q%0d", i));
        end
        rd(REG_STATUS, 0, "stall_status_empty");
        // abort mid-ACCUM of the third point keeps the two finished entries
        cfg(100, 1, 5, 10, 0);
        wr(REG_CTRL, 1);
        repeat (30) @(negedge clk);
        wr(REG_CTRL, 2);
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_freq", freq, 102);
        rd(REG_STATUS, 32'h0002_0000, "abort_status");
        rd(REG_I_LO, 10, "abort_i_lo");
        rd(REG_Q_LO, 20, "abort_q_lo");
        rd(REG_Q_HI, 0, "abort_pop");
        rd(REG_STATUS, 32'h0001_0000, "abort_status_after_pop");
        // asynchronous reset mid-sweep
        cfg(7, 1, 5, 10, 0);
        wr(REG_CTRL, 1);
        repeat (15) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("arst_freq", freq, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_upd", {31'd0, freq_upd}, 0);
        chk("arst_rdata", bus.rdata, 0);
        @(negedge clk);
        rstn = 1'b1;
        rd(REG_START, 0, "arst_start_reg");
        rd(REG_STATUS, 0, "arst_status");
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
